// File: rtl/adder_bist_pkg.sv
// rtl/adder_bist_pkg.sv - shared types and polynomial tables for the adder BIST controller
package adder_bist_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        RUN     = 3'd2,
        DRAIN   = 3'd3,
        COMPARE = 3'd4,
        DONE    = 3'd5
    } bist_state_e;

    // Mask bit k-1 is set for polynomial term x^k; the constant term is implicit.
    function automatic logic [63:0] poly_taps(input int unsigned w);
        logic [63:0] m;
        case (w)
            2:       m = 64'h3;
            3:       m = 64'h6;
            4:       m = 64'hC;
            5:       m = 64'h14;
            6:       m = 64'h30;
            7:       m = 64'h60;
            9:       m = 64'h110;
            10:      m = 64'h240;
            11:      m = 64'h500;
            15:      m = 64'h6000;
            17:      m = 64'h12000;
            33:      m = 64'h1_0008_0000;
            default: m = (64'd1 << (w - 1)) | (64'd1 << (w - 2));
        endcase
        return m;
    endfunction

    function automatic logic [63:0] lfsr_taps(input int unsigned w);
        return poly_taps(w);
    endfunction

    function automatic logic [63:0] misr_taps(input int unsigned w);
        return poly_taps(w);
    endfunction

endpackage

// File: rtl/adder_bist_lfsr.sv
// rtl/adder_bist_lfsr.sv - Fibonacci shift register, optionally compacting parallel input (MISR)
module adder_bist_lfsr #(
    parameter int           W         = 9,
    parameter logic [W-1:0] TAPS      = '0,
    parameter bit           MISR_MODE = 1'b0,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_en,
    input  logic [W-1:0] load_val,
    input  logic         step_en,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] state_q
);

    logic [W-1:0] state_d;
    logic         fb;

    always_comb begin
        fb      = ^(state_q & TAPS);
        state_d = state_q;
        if (load_en) begin
            state_d = load_val;
        end else if (step_en) begin
            state_d = {state_q[W-2:0], fb};
            if (MISR_MODE) begin
                state_d = state_d ^ data_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_VAL;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/adder_bist_ctrl.sv
// rtl/adder_bist_ctrl.sv - BIST sequencer: LFSR patterns into the adder, MISR compaction, golden compare
module adder_bist_ctrl
    import adder_bist_pkg::*;
#(
    parameter int               N            = 16,
    parameter int               NUM_PATTERNS = 256,
    parameter int               RESP_LAT     = 0,
    parameter logic [2*N:0]     LFSR_SEED    = (2*N+1)'(1),
    parameter logic [N:0]       GOLDEN_SIG   = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         bist_start,
    input  logic         bist_abort,
    input  logic [N-1:0] sum_in,
    input  logic         cout_in,
    output logic [N-1:0] pat_a,
    output logic [N-1:0] pat_b,
    output logic         pat_cin,
    output logic         mux_sel,
    output logic         bist_busy,
    output logic         bist_done,
    output logic         bist_pass,
    output logic [N:0]   signature
);

    localparam int LW  = 2 * N + 1;
    localparam int MW  = N + 1;
    localparam int CW  = $clog2(NUM_PATTERNS + 1);
    localparam int DCW = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;
    localparam int VW  = RESP_LAT + 1;

    localparam logic [LW-1:0]  LFSR_TAPS  = LW'(lfsr_taps(LW));
    localparam logic [MW-1:0]  MISR_TAPS  = MW'(misr_taps(MW));
    localparam logic [CW-1:0]  LAST_CNT   = CW'(NUM_PATTERNS - 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'((RESP_LAT > 0) ? RESP_LAT - 1 : 0);

    if (LFSR_SEED == '0) begin : g_seed_check
        $error("adder_bist_ctrl: LFSR_SEED must be nonzero");
    end
    if (NUM_PATTERNS < 1) begin : g_count_check
        $error("adder_bist_ctrl: NUM_PATTERNS must be at least 1");
    end

    bist_state_e     state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DCW-1:0]  dcnt_q, dcnt_d;
    logic [VW-1:0]   vld_q, vld_d;
    logic [LW-1:0]   pat_q, pat_d;
    logic [MW-1:0]   sig_q, sig_d;
    logic            mux_sel_q, mux_sel_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;

    logic [LW-1:0]   lfsr_q;
    logic [MW-1:0]   misr_q;
    logic            in_test;
    logic            lfsr_load;
    logic            lfsr_step;
    logic            capture;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bist_start && !bist_abort) state_d = SETUP;
            SETUP:   state_d = RUN;
            RUN:     if (cnt_q == LAST_CNT) state_d = (RESP_LAT == 0) ? COMPARE : DRAIN;
            DRAIN:   if (dcnt_q == DRAIN_LAST) state_d = COMPARE;
            COMPARE: state_d = DONE;
            DONE:    if (!bist_start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bist_abort && state_q != IDLE) begin
            state_d = IDLE;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        in_test   = state_d inside {SETUP, RUN, DRAIN, COMPARE};
        busy_d    = in_test;
        mux_sel_d = !in_test;
        done_d    = (state_d == DONE);

        cnt_d  = (state_q == SETUP) ? '0 : ((state_q == RUN) ? cnt_q + 1'b1 : cnt_q);
        dcnt_d = (state_q == DRAIN) ? dcnt_q + 1'b1 : '0;

        if (state_d inside {IDLE, SETUP}) begin
            vld_d = '0;
        end else begin
            vld_d = VW'({vld_q, state_d == RUN});
        end

        if (state_d == RUN) begin
            pat_d = lfsr_q;
        end else if (state_d == IDLE) begin
            pat_d = '0;
        end else begin
            pat_d = pat_q;
        end

        sig_d  = (state_q == COMPARE && state_d == DONE) ? misr_q : sig_q;
        pass_d = 1'b0;
        if (state_d == DONE) begin
            pass_d = (state_q == COMPARE) ? (misr_q == GOLDEN_SIG) : pass_q;
        end
    end

    // The LFSR runs one step ahead of pat_q, so it is seeded on entry to SETUP.
    assign lfsr_load = (state_q == IDLE) && (state_d == SETUP);
    assign lfsr_step = state_q inside {SETUP, RUN};
    assign capture   = vld_q[RESP_LAT];

    adder_bist_lfsr #(
        .W         (LW),
        .TAPS      (LFSR_TAPS),
        .MISR_MODE (1'b0),
        .RESET_VAL (LFSR_SEED)
    ) u_pat_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_en  (lfsr_load),
        .load_val (LFSR_SEED),
        .step_en  (lfsr_step),
        .data_in  ('0),
        .state_q  (lfsr_q)
    );

    adder_bist_lfsr #(
        .W         (MW),
        .TAPS      (MISR_TAPS),
        .MISR_MODE (1'b1),
        .RESET_VAL ('0)
    ) u_resp_misr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_en  (state_q == SETUP),
        .load_val ('0),
        .step_en  (capture),
        .data_in  ({cout_in, sum_in}),
        .state_q  (misr_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dcnt_q    <= '0;
            vld_q     <= '0;
            pat_q     <= '0;
            sig_q     <= '0;
            mux_sel_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dcnt_q    <= dcnt_d;
            vld_q     <= vld_d;
            pat_q     <= pat_d;
            sig_q     <= sig_d;
            mux_sel_q <= mux_sel_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end

    assign pat_a     = pat_q[2*N:N+1];
    assign pat_b     = pat_q[N:1];
    assign pat_cin   = pat_q[0];
    assign mux_sel   = mux_sel_q;
    assign bist_busy = busy_q;
    assign bist_done = done_q;
    assign bist_pass = pass_q;
    assign signature = sig_q;

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// tb/tb_adder_bist_ctrl.sv - directed bench for adder_bist_ctrl, N=4, 8 patterns, latency 0 and 2
module tb_adder_bist_ctrl;

    localparam logic [8:0]  SEED    = 9'h1A5;
    localparam logic [17:0] RST_VEC = {1'b1, 3'b000, 5'h00, 9'h000};

    // Reference: x^9+x^5+1 pattern LFSR, 4-bit adder, x^5+x^3+1 MISR starting from zero.
    function automatic logic [4:0] model_sig(input logic [8:0] seed, input int np, input bit fault);
        logic [8:0] s;
        logic [4:0] m;
        logic [4:0] r;
        s = seed;
        m = '0;
        for (int i = 0; i < np; i++) begin
            r = {1'b0, s[8:5]} + {1'b0, s[4:1]} + {4'b0, s[0]};
            if (fault) r[0] = 1'b0;
            m = {m[3:0], m[4] ^ m[2]} ^ r;
            s = {s[7:0], s[8] ^ s[4]};
        end
        return m;
    endfunction

    localparam logic [4:0] GOLDEN    = model_sig(SEED, 8, 1'b0);
    localparam logic [4:0] FAULT_SIG = model_sig(SEED, 8, 1'b1);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start0 = 1'b0;
    logic       start2 = 1'b0;
    logic       abort = 1'b0;
    logic       fault0 = 1'b0;

    logic [3:0] pa0, pb0, pa2, pb2, sum0, sum2;
    logic       pc0, pc2, cout0, cout2;
    logic       mux0, busy0, done0, pass0, mux2, busy2, done2, pass2;
    logic [4:0] sig0, sig2, add0, r1, r2;
    logic [17:0] obs0, obs2;

    int tests_run = 0;
    int failed = 0;
    int bc, ml;
    logic d, p;
    logic [4:0] s;

    always #5 clk = ~clk;

    assign add0  = {1'b0, pa0} + {1'b0, pb0} + {4'b0, pc0};
    assign sum0  = fault0 ? {add0[3:1], 1'b0} : add0[3:0];
    assign cout0 = add0[4];

    always_ff @(posedge clk) begin
        r1 <= {1'b0, pa2} + {1'b0, pb2} + {4'b0, pc2};
        r2 <= r1;
    end
    assign sum2  = r2[3:0];
    assign cout2 = r2[4];

    assign obs0 = {mux0, busy0, done0, pass0, sig0, pa0, pb0, pc0};
    assign obs2 = {mux2, busy2, done2, pass2, sig2, pa2, pb2, pc2};

    adder_bist_ctrl #(
        .N(4), .NUM_PATTERNS(8), .RESP_LAT(0), .LFSR_SEED(SEED), .GOLDEN_SIG(GOLDEN)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .bist_start(start0), .bist_abort(abort),
        .sum_in(sum0), .cout_in(cout0), .pat_a(pa0), .pat_b(pb0), .pat_cin(pc0),
        .mux_sel(mux0), .bist_busy(busy0), .bist_done(done0), .bist_pass(pass0),
        .signature(sig0)
    );

    adder_bist_ctrl #(
        .N(4), .NUM_PATTERNS(8), .RESP_LAT(2), .LFSR_SEED(SEED), .GOLDEN_SIG(GOLDEN)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .bist_start(start2), .bist_abort(abort),
        .sum_in(sum2), .cout_in(cout2), .pat_a(pa2), .pat_b(pb2), .pat_cin(pc2),
        .mux_sel(mux2), .bist_busy(busy2), .bist_done(done2), .bist_pass(pass2),
        .signature(sig2)
    );

    task automatic set_start(input int which, input logic v);
        if (which == 0) start0 = v;
        else start2 = v;
    endtask

    // Launch a run and count busy / mux-low cycles until busy drops; results land in bc/ml/d/p/s.
    task automatic run_measure(input int which, input bit hold, input int pulse_at);
        logic b, m;
        @(negedge clk);
        set_start(which, 1'b1);
        @(negedge clk);
        set_start(which, hold);
        bc = 0;
        ml = 0;
        for (int k = 0; k < 200; k++) begin
            b = (which == 0) ? busy0 : busy2;
            m = (which == 0) ? mux0 : mux2;
            if (!b) break;
            bc++;
            if (!m) ml++;
            if (!hold) set_start(which, k == pulse_at);
            @(negedge clk);
        end
        if (!hold) set_start(which, 1'b0);
        d = (which == 0) ? done0 : done2;
        p = (which == 0) ? pass0 : pass2;
        s = (which == 0) ? sig0 : sig2;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests_run++;
        if (obs0 !== RST_VEC) begin failed++; $display("FAIL reset_in_reset_dut0: got %h want %h", obs0, RST_VEC); end
        tests_run++;
        if (obs2 !== RST_VEC) begin failed++; $display("FAIL reset_in_reset_dut2: got %h want %h", obs2, RST_VEC); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (obs0 !== RST_VEC) begin failed++; $display("FAIL reset_idle_dut0: got %h want %h", obs0, RST_VEC); end
    endtask

    task automatic test_pass_run();
        run_measure(0, 1'b0, -1);
        tests_run++;
        if (bc !== 10) begin failed++; $display("FAIL t1_busy_cycles: got %0d want 10", bc); end
        tests_run++;
        if (ml !== 10) begin failed++; $display("FAIL t1_mux_low_cycles: got %0d want 10", ml); end
        tests_run++;
        if ({d, p, mux0} !== 3'b111) begin failed++; $display("FAIL t1_done_pass_mux: got %b want 111", {d, p, mux0}); end
        tests_run++;
        if (s !== GOLDEN) begin failed++; $display("FAIL t1_signature: got %h want %h", s, GOLDEN); end
        @(negedge clk);
        tests_run++;
        if ({done0, busy0, mux0} !== 3'b001) begin failed++; $display("FAIL t1_back_to_idle: got %b want 001", {done0, busy0, mux0}); end
    endtask

    task automatic test_stuck_at();
        fault0 = 1'b1;
        run_measure(0, 1'b0, -1);
        fault0 = 1'b0;
        tests_run++;
        if (bc !== 10) begin failed++; $display("FAIL t2_busy_cycles: got %0d want 10", bc); end
        tests_run++;
        if ({d, p} !== 2'b10) begin failed++; $display("FAIL t2_done_pass: got %b want 10", {d, p}); end
        tests_run++;
        if (s !== FAULT_SIG) begin failed++; $display("FAIL t2_signature: got %h want %h", s, FAULT_SIG); end
        tests_run++;
        if (s === GOLDEN) begin failed++; $display("FAIL t2_sig_differs: got %h want not %h", s, GOLDEN); end
    endtask

    task automatic test_abort();
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        tests_run++;
        if ({busy0, mux0} !== 2'b10) begin failed++; $display("FAIL t3_setup: got %b want 10", {busy0, mux0}); end
        @(negedge clk);
        tests_run++;
        if ({pa0, pb0, pc0} !== 9'h1A5) begin failed++; $display("FAIL t3_pattern0: got %h want 1a5", {pa0, pb0, pc0}); end
        repeat (3) @(negedge clk);
        tests_run++;
        if ({pa0, pb0, pc0} !== 9'h12F) begin failed++; $display("FAIL t3_pattern3: got %h want 12f", {pa0, pb0, pc0}); end
        abort = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({mux0, busy0, done0, pass0} !== 4'b1000) begin
            failed++; $display("FAIL t3_abort_outputs: got %b want 1000", {mux0, busy0, done0, pass0});
        end
        abort = 1'b0;
        run_measure(0, 1'b0, -1);
        tests_run++;
        if ({bc[4:0], d, p} !== {5'd10, 2'b11}) begin failed++; $display("FAIL t3_restart_timing: got %0d/%b%b want 10/11", bc, d, p); end
        tests_run++;
        if (s !== GOLDEN) begin failed++; $display("FAIL t3_restart_signature: got %h want %h", s, GOLDEN); end
    endtask

    task automatic test_resp_latency();
        run_measure(2, 1'b0, -1);
        tests_run++;
        if (bc !== 12) begin failed++; $display("FAIL t4_busy_cycles: got %0d want 12", bc); end
        tests_run++;
        if (ml !== 12) begin failed++; $display("FAIL t4_mux_low_cycles: got %0d want 12", ml); end
        tests_run++;
        if ({d, p} !== 2'b11) begin failed++; $display("FAIL t4_done_pass: got %b want 11", {d, p}); end
        tests_run++;
        if (s !== GOLDEN) begin failed++; $display("FAIL t4_signature: got %h want %h", s, GOLDEN); end
        tests_run++;
        if (busy0 !== 1'b0) begin failed++; $display("FAIL t4_other_idle: got %b want 0", busy0); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (6) @(negedge clk);
        tests_run++;
        if (busy0 !== 1'b1) begin failed++; $display("FAIL t5_running: got %b want 1", busy0); end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (obs0 !== RST_VEC) begin failed++; $display("FAIL t5_async_reset: got %h want %h", obs0, RST_VEC); end
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (obs0 !== RST_VEC) begin failed++; $display("FAIL t5_after_release: got %h want %h", obs0, RST_VEC); end
        run_measure(0, 1'b0, -1);
        tests_run++;
        if ({bc[4:0], d, p} !== {5'd10, 2'b11} || s !== GOLDEN) begin
            failed++; $display("FAIL t5_restart: got %0d/%b%b/%h want 10/11/%h", bc, d, p, s, GOLDEN);
        end
    endtask

    task automatic test_back_to_back();
        int held;
        run_measure(0, 1'b1, -1);
        tests_run++;
        if ({bc[4:0], d} !== {5'd10, 1'b1}) begin failed++; $display("FAIL t6_held_run: got %0d/%b want 10/1", bc, d); end
        held = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done0 && !busy0) held++;
        end
        tests_run++;
        if (held !== 5) begin failed++; $display("FAIL t6_stay_done: got %0d want 5", held); end
        start0 = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({done0, busy0} !== 2'b00) begin failed++; $display("FAIL t6_release_idle: got %b want 00", {done0, busy0}); end
        run_measure(0, 1'b0, 3);
        tests_run++;
        if ({bc[4:0], d, p} !== {5'd10, 2'b11}) begin failed++; $display("FAIL t6_pulse_ignored: got %0d/%b%b want 10/11", bc, d, p); end
        held = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (busy0 || done0) held++;
        end
        tests_run++;
        if (held !== 0) begin failed++; $display("FAIL t6_no_second_run: got %0d active cycles want 0", held); end
    endtask

    initial begin
        test_reset();
        test_pass_run();
        test_stuck_at();
        test_abort();
        test_resp_latency();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
